// File: rtl/ras_ctrl.sv
// Fetch-stage return address stack controller: classifies calls/returns/swaps, drives stack commands, predicts return targets.
// Optional statistics counters are enabled by defining RAS_CTRL_STATS_EN.
module ras_ctrl #(
    parameter int RAS_SIZE = 8,
    parameter int ADDR_W   = 48
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              fetch_valid,
    output logic              fetch_ready,
    input  logic [ADDR_W-1:0] fetch_pc,
    input  logic              is_jal,
    input  logic              is_jalr,
    input  logic              is_rvc,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic              redir_valid,
    output logic              ras_push,
    output logic              ras_pop,
    output logic              ras_replace,
    output logic              ras_flush,
    output logic [ADDR_W-1:0] ras_idata,
    input  logic [ADDR_W-1:0] ras_odata,
    output logic              pred_valid,
    output logic [ADDR_W-1:0] pred_target
`ifdef RAS_CTRL_STATS_EN
    ,
    output logic [31:0]       stat_calls,
    output logic [31:0]       stat_rets,
    output logic [31:0]       stat_underflows,
    output logic [31:0]       stat_overflows
`endif
);

    localparam int CW = $clog2(RAS_SIZE) + 1;
    localparam logic [CW-1:0] FULL = CW'(RAS_SIZE);

    typedef enum logic [1:0] {
        ST_INIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_RECOVER = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     count_q, count_d;
    logic              pred_valid_q, pred_valid_d;
    logic [ADDR_W-1:0] pred_target_q, pred_target_d;

    logic accept, link_rd, link_rs1;
    logic is_call, is_ret, is_swap, has_entry;
    logic do_push, do_pop, do_repl, underflow, overflow;

    always_comb begin
        fetch_ready = (state_q == ST_RUN) && !redir_valid;
        accept      = fetch_valid && fetch_ready;
        link_rd     = (rd == 5'd1) || (rd == 5'd5);
        link_rs1    = (rs1 == 5'd1) || (rs1 == 5'd5);
        is_call     = (is_jal && link_rd) || (is_jalr && link_rd && (!link_rs1 || (rs1 == rd)));
        is_ret      = is_jalr && !link_rd && link_rs1;
        is_swap     = is_jalr && link_rd && link_rs1 && (rs1 != rd);
        has_entry   = (count_q != '0);

        // A swap on an empty stack has nothing to replace, so it degrades to a plain call.
        do_push   = accept && (is_call || (is_swap && !has_entry));
        do_pop    = accept && is_ret && has_entry;
        do_repl   = accept && is_swap && has_entry;
        underflow = accept && is_ret && !has_entry;
        overflow  = do_push && (count_q == FULL);

        ras_push    = do_push;
        ras_pop     = do_pop;
        ras_replace = do_repl;
        ras_flush   = (state_q != ST_RUN) || redir_valid;
        ras_idata   = fetch_pc + (is_rvc ? ADDR_W'(2) : ADDR_W'(4));

        count_d = count_q;
        if (ras_flush) begin
            count_d = '0;
        end else if (do_push && !overflow) begin
            count_d = count_q + CW'(1);
        end else if (do_pop) begin
            count_d = count_q - CW'(1);
        end

        state_d = state_q;
        if (redir_valid) begin
            state_d = ST_RECOVER;
        end else if (state_q != ST_RUN) begin
            state_d = ST_RUN;
        end

        pred_valid_d  = do_pop || do_repl;
        pred_target_d = pred_valid_d ? ras_odata : pred_target_q;
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= ST_INIT;
            count_q       <= '0;
            pred_valid_q  <= 1'b0;
            pred_target_q <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            pred_valid_q  <= pred_valid_d;
            pred_target_q <= pred_target_d;
        end
    end

    assign pred_valid  = pred_valid_q;
    assign pred_target = pred_target_q;

`ifdef RAS_CTRL_STATS_EN
    logic [31:0] calls_q, calls_d, rets_q, rets_d;
    logic [31:0] unders_q, unders_d, overs_q, overs_d;

    // Counters survive redirects; only reset clears them.
    always_comb begin
        calls_d  = calls_q + 32'(do_push);
        rets_d   = rets_q + 32'(do_pop || do_repl);
        unders_d = unders_q + 32'(underflow);
        overs_d  = overs_q + 32'(overflow);
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            calls_q  <= '0;
            rets_q   <= '0;
            unders_q <= '0;
            overs_q  <= '0;
        end else begin
            calls_q  <= calls_d;
            rets_q   <= rets_d;
            unders_q <= unders_d;
            overs_q  <= overs_d;
        end
    end

    assign stat_calls      = calls_q;
    assign stat_rets       = rets_q;
    assign stat_underflows = unders_q;
    assign stat_overflows  = overs_q;
`endif

endmodule

// File: tb/tb_ras_ctrl.sv
// Directed bench for ras_ctrl with a small circular stack model standing in for the real RAS.
module tb_ras_ctrl;
    localparam int RAS_SIZE = 8;
    localparam int ADDR_W   = 48;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              fetch_valid = 1'b0;
    logic              fetch_ready;
    logic [ADDR_W-1:0] fetch_pc = '0;
    logic              is_jal = 1'b0;
    logic              is_jalr = 1'b0;
    logic              is_rvc = 1'b0;
    logic [4:0]        rd = '0;
    logic [4:0]        rs1 = '0;
    logic              redir_valid = 1'b0;
    logic              ras_push, ras_pop, ras_replace, ras_flush;
    logic [ADDR_W-1:0] ras_idata, ras_odata;
    logic              pred_valid;
    logic [ADDR_W-1:0] pred_target;
`ifdef RAS_CTRL_STATS_EN
    logic [31:0] stat_calls, stat_rets, stat_underflows, stat_overflows;
`endif

    int total = 0;
    int bad   = 0;

    ras_ctrl #(.RAS_SIZE(RAS_SIZE), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .n_reset(n_reset),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready), .fetch_pc(fetch_pc),
        .is_jal(is_jal), .is_jalr(is_jalr), .is_rvc(is_rvc), .rd(rd), .rs1(rs1),
        .redir_valid(redir_valid),
        .ras_push(ras_push), .ras_pop(ras_pop), .ras_replace(ras_replace), .ras_flush(ras_flush),
        .ras_idata(ras_idata), .ras_odata(ras_odata),
        .pred_valid(pred_valid), .pred_target(pred_target)
`ifdef RAS_CTRL_STATS_EN
        ,
        .stat_calls(stat_calls), .stat_rets(stat_rets),
        .stat_underflows(stat_underflows), .stat_overflows(stat_overflows)
`endif
    );

    always #5 clk = ~clk;

    // Circular stack: pushing past capacity overwrites the oldest entry.
    logic [ADDR_W-1:0] stk [RAS_SIZE];
    logic [2:0]        sp = '0;
    assign ras_odata = stk[sp];

    always @(posedge clk) begin
        if (ras_flush) begin
            sp <= '0;
        end else if (ras_push) begin
            sp <= sp + 3'd1;
            stk[sp + 3'd1] <= ras_idata;
        end else if (ras_pop) begin
            sp <= sp - 3'd1;
        end else if (ras_replace) begin
            stk[sp] <= ras_idata;
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic issue(input logic jal, input logic jalr, input logic rvc,
                         input logic [4:0] d, input logic [4:0] s, input logic [ADDR_W-1:0] pc);
        fetch_valid = 1'b1;
        is_jal      = jal;
        is_jalr     = jalr;
        is_rvc      = rvc;
        rd          = d;
        rs1         = s;
        fetch_pc    = pc;
        #1;
    endtask

    task automatic next_cycle();
        @(negedge clk);
        fetch_valid = 1'b0;
        is_jal      = 1'b0;
        is_jalr     = 1'b0;
        redir_valid = 1'b0;
        #1;
    endtask

    initial begin
        for (int i = 0; i < RAS_SIZE; i++) stk[i] = '0;

        // Reset and idle
        repeat (3) @(negedge clk);
        check("rst_pred_valid", 64'(pred_valid), 64'd0);
        check("rst_pred_target", 64'(pred_target), 64'd0);
        check("rst_cmds", {61'd0, ras_push, ras_pop, ras_replace}, 64'd0);
        n_reset = 1'b1;
        #1;
        check("init_flush", 64'(ras_flush), 64'd1);
        check("init_ready", 64'(fetch_ready), 64'd0);
        next_cycle();
        check("run_flush", 64'(ras_flush), 64'd0);
        check("run_ready", 64'(fetch_ready), 64'd1);
        check("run_pred_valid", 64'(pred_valid), 64'd0);

        // Basic call / return
        issue(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 48'h1000);
        check("t2_push", 64'(ras_push), 64'd1);
        check("t2_idata", 64'(ras_idata), 64'h1004);
        next_cycle();
        check("t2_no_pred", 64'(pred_valid), 64'd0);
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 48'h1004);
        check("t2_pop", {62'd0, ras_pop, ras_push}, 64'd2);
        next_cycle();
        check("t2_pred_valid", 64'(pred_valid), 64'd1);
        check("t2_pred_target", 64'(pred_target), 64'h1004);
        next_cycle();
        check("t2_pulse_end", 64'(pred_valid), 64'd0);
        check("t2_target_hold", 64'(pred_target), 64'h1004);

        // Overflow then drain to underflow
        for (int i = 1; i <= 9; i++) begin
            issue(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 48'(i * 'h100));
            check("t3_push", 64'(ras_push), 64'd1);
            next_cycle();
        end
        for (int k = 0; k < 9; k++) begin
            issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd5, 48'h5000);
            check("t3_pop", 64'(ras_pop), 64'(k < 8));
            next_cycle();
            check("t3_pred_valid", 64'(pred_valid), 64'(k < 8));
            if (k < 8) check("t3_pred_target", 64'(pred_target), 64'((9 - k) * 'h100 + 2));
        end
        check("t3_target_hold", 64'(pred_target), 64'h202);
`ifdef RAS_CTRL_STATS_EN
        check("stat_calls", 64'(stat_calls), 64'd10);
        check("stat_rets", 64'(stat_rets), 64'd9);
        check("stat_underflows", 64'(stat_underflows), 64'd1);
        check("stat_overflows", 64'(stat_overflows), 64'd1);
`endif

        // Coroutine swap
        issue(1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 48'h2000);
        next_cycle();
        issue(1'b0, 1'b1, 1'b0, 5'd1, 5'd5, 48'h3000);
        check("t4_cmds", {61'd0, ras_push, ras_pop, ras_replace}, 64'd1);
        check("t4_idata", 64'(ras_idata), 64'h3004);
        next_cycle();
        check("t4_pred_valid", 64'(pred_valid), 64'd1);
        check("t4_pred_target", 64'(pred_target), 64'h2004);
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 48'h3004);
        check("t4_ret_pop", 64'(ras_pop), 64'd1);
        next_cycle();
        check("t4_ret_target", 64'(pred_target), 64'h3004);

        // Redirect flush and recovery
        issue(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 48'h4000);
        next_cycle();
        issue(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 48'h4100);
        next_cycle();
        redir_valid = 1'b1;
        issue(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 48'h4200);
        check("t5_ready", 64'(fetch_ready), 64'd0);
        check("t5_flush", 64'(ras_flush), 64'd1);
        check("t5_no_push", 64'(ras_push), 64'd0);
        next_cycle();
        check("t5_recover_ready", 64'(fetch_ready), 64'd0);
        next_cycle();
        check("t5_run_ready", 64'(fetch_ready), 64'd1);
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 48'h4300);
        check("t5_underflow_pop", 64'(ras_pop), 64'd0);
        next_cycle();
        check("t5_underflow_pred", 64'(pred_valid), 64'd0);

        // Swap on empty stack, same-register call, non-link jalr, pc wrap
        issue(1'b0, 1'b1, 1'b0, 5'd5, 5'd1, 48'h6000);
        check("t6_swap_empty", {61'd0, ras_push, ras_pop, ras_replace}, 64'd4);
        next_cycle();
        check("t6_swap_empty_pred", 64'(pred_valid), 64'd0);
        issue(1'b0, 1'b1, 1'b0, 5'd5, 5'd5, 48'h6100);
        check("t6_same_reg_call", {61'd0, ras_push, ras_pop, ras_replace}, 64'd4);
        next_cycle();
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd2, 48'h6200);
        check("t6_none", {61'd0, ras_push, ras_pop, ras_replace}, 64'd0);
        next_cycle();
        issue(1'b1, 1'b0, 1'b1, 5'd1, 5'd0, 48'hFFFF_FFFF_FFFE);
        check("t6_wrap_idata", 64'(ras_idata), 64'd0);
        next_cycle();

        // Redirect right after an accepted return still lets the prediction pulse
        issue(1'b0, 1'b1, 1'b0, 5'd0, 5'd1, 48'h7000);
        check("t7_pop", 64'(ras_pop), 64'd1);
        next_cycle();
        redir_valid = 1'b1;
        #1;
        check("t7_pred_with_redir", 64'(pred_valid), 64'd1);
        check("t7_target", 64'(pred_target), 64'h0);
        next_cycle();

        // Reset mid-operation
        issue(1'b1, 1'b0, 1'b0, 5'd1, 5'd0, 48'h8000);
        n_reset = 1'b0;
        #1;
        check("t8_rst_ready", 64'(fetch_ready), 64'd0);
        check("t8_rst_flush", 64'(ras_flush), 64'd1);
        check("t8_rst_target", 64'(pred_target), 64'd0);
        next_cycle();
        n_reset = 1'b1;
        next_cycle();
        check("t8_run_ready", 64'(fetch_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
